ext_frame_mem_ctrl: RTL and testbench
=====================================

// Module: ext_frame_mem_ctrl
// PURPOSE
//  Sequencer between the mandelbrot core / VGA scan-out and the external 4-bit sequential frame memory on uio.
//  Write side takes 4-bit iteration counts from the core over a valid/ready handshake.
//  It emits write strobes and write-pointer resets to memory (uio_out[5:0]).
//  Read side serves pixel requests from VGA scan-out with read strobes and read-pointer resets (uio_out[7:6], data on uio_in[3:0]).
// PARAMETERS
//  WR_PULSE      2      cycles mem_write is held high per pixel (>=1)
//  RD_LATENCY    2      cycles from mem_read rise to valid mem_read_data (>=1)
//  FRAME_PIXELS  19200  pixels per frame; write side stalls after this many until frame_start
// PORTS
//  clk                  in   1  system clock
//  rst_n                in   1  asynchronous active-low reset
//  frame_start          in   1  1-cycle pulse: core begins new image
//  pix_valid            in   1  core offers pix_data
//  pix_data             in   4  iteration count of current pixel
//  pix_ready            out  1  controller accepts pixel this cycle
//  frame_full           out  1  FRAME_PIXELS written since last frame_start
//  mem_write            out  1  write strobe to external memory (uio_out[5])
//  mem_reset_write_ptr  out  1  write-pointer reset strobe (uio_out[4])
//  mem_write_data       out  4  write data (uio_out[3:0])
//  rd_frame_start       in   1  1-cycle pulse from VGA timing (start of visible frame)
//  rd_req               in   1  1-cycle pulse: VGA needs next pixel
//  rd_busy              out  1  read side not idle; rd_req ignored while high
//  rd_valid             out  1  1-cycle pulse: rd_data holds requested pixel
//  rd_data              out  4  last pixel read
//  mem_read             out  1  read strobe (uio_out[7])
//  mem_reset_read_ptr   out  1  read-pointer reset strobe (uio_out[6])
//  mem_read_data        in   4  data from memory (uio_in[3:0])
// BEHAVIOUR
//  Reset (async, rst_n=0): all outputs 0. Both FSMs idle. Pixel counter 0. No pending pointer reset.
//  Write FSM: W_IDLE -> W_SETUP(1) -> W_STROBE(WR_PULSE) -> W_HOLD(1) -> W_IDLE; W_PRST(1) for pointer reset.
//  pix_ready = (state==W_IDLE) & ~frame_full & ~prst_pending. Transfer on pix_valid&pix_ready at cycle T.
//  Write timing:
//   - T+1: mem_write_data <= pix_data, held until next transfer.
//   - T+2 .. T+1+WR_PULSE: mem_write=1.
//   - T+2+WR_PULSE: W_HOLD.
//   - T+3+WR_PULSE: pix_ready may rise again.
//  Counter increments on transfer. frame_full=1 when count==FRAME_PIXELS; no wrap.
//  frame_start: sets prst_pending. Taken only in W_IDLE; an in-flight write completes first.
//   - W_PRST: mem_reset_write_ptr=1 for exactly 1 cycle. Counter and frame_full cleared, prst_pending cleared.
//   - frame_start and a transfer in the same cycle: the transfer is refused (pix_ready already low next cycle is insufficient, so pix_ready is combinationally gated by frame_start).
//  Read FSM: R_IDLE -> R_STROBE(1) -> R_WAIT(RD_LATENCY-1) -> R_CAP(1) -> R_IDLE; R_PRST(1).
//  Read timing:
//   - rd_req in R_IDLE at T: mem_read=1 at T+1 only.
//   - mem_read_data sampled at end of cycle T+RD_LATENCY, into rd_data.
//   - rd_valid=1 at T+1+RD_LATENCY.
//  rd_busy=1 in every state except R_IDLE. rd_req while busy is dropped, not queued.
//  rd_frame_start from any read state, same cycle as rd_req included:
//   - Aborts the read; no rd_valid for it.
//   - Next cycle R_PRST, mem_reset_read_ptr=1 for 1 cycle, then R_IDLE. rd_data keeps its old value.
//  Read and write sides are fully independent. Simultaneous mem_write and mem_read are permitted.
//  mem_write and mem_reset_write_ptr are never high together. Same for mem_read and mem_reset_read_ptr.
// TESTING
//  1 Reset mid-W_STROBE (rst_n low 1 cycle) -> all outputs 0 same cycle; pix_ready=1 after release.
//  2 pix_valid=1,pix_data=4'hA at T -> mem_write_data=A at T+1; mem_write=1 at T+2,T+3; pix_ready=1 at T+5.
//  3 FRAME_PIXELS=4: stream 6 pixels back-to-back -> exactly 4 mem_write bursts, frame_full=1.
//    Then frame_start -> one mem_reset_write_ptr pulse, frame_full=0, pixel 5 accepted.
//  4 frame_start during W_STROBE -> strobe completes WR_PULSE cycles; mem_reset_write_ptr 2 cycles after W_HOLD; no overlap.
//  5 rd_req at T, mem_read_data=4'h7 from T+2 -> mem_read=1 at T+1, rd_data=7, rd_valid=1 at T+3.
//    rd_req at T+1 is ignored.
//  6 rd_frame_start at T+1 of a read -> no rd_valid; mem_reset_read_ptr=1 at T+2; rd_busy=0 at T+3.

Source files
------------

// File: rtl/ext_frame_mem_ctrl_if.sv
// Bundle of the core pixel stream, VGA read requests and external frame-memory strobes.
// The slave view belongs to the controller; the master view is the surrounding system.
interface ext_frame_mem_ctrl_if;
  logic       frame_start;
  logic       pix_valid;
  logic [3:0] pix_data;
  logic       pix_ready;
  logic       frame_full;
  logic       mem_write;
  logic       mem_reset_write_ptr;
  logic [3:0] mem_write_data;
  logic       rd_frame_start;
  logic       rd_req;
  logic       rd_busy;
  logic       rd_valid;
  logic [3:0] rd_data;
  logic       mem_read;
  logic       mem_reset_read_ptr;
  logic [3:0] mem_read_data;

  modport slave (
    input  frame_start, pix_valid, pix_data, rd_frame_start, rd_req, mem_read_data,
    output pix_ready, frame_full, mem_write, mem_reset_write_ptr, mem_write_data,
           rd_busy, rd_valid, rd_data, mem_read, mem_reset_read_ptr
  );

  modport master (
    output frame_start, pix_valid, pix_data, rd_frame_start, rd_req, mem_read_data,
    input  pix_ready, frame_full, mem_write, mem_reset_write_ptr, mem_write_data,
           rd_busy, rd_valid, rd_data, mem_read, mem_reset_read_ptr
  );
endinterface

// File: rtl/ext_frame_mem_ctrl.sv
// Sequencer for the external 4-bit sequential frame memory: independent write side
// (core pixels) and read side (VGA scan-out), each with its own pointer-reset path.
module ext_frame_mem_ctrl #(
  parameter int unsigned WR_PULSE     = 2,
  parameter int unsigned RD_LATENCY   = 2,
  parameter int unsigned FRAME_PIXELS = 19200
) (
  input  logic                 clk,
  input  logic                 rst_n,
  ext_frame_mem_ctrl_if.slave  bus
);
  localparam int unsigned CW = $clog2(FRAME_PIXELS + 1);
  localparam int unsigned WW = $clog2(WR_PULSE + 1);
  localparam int unsigned RW = $clog2(RD_LATENCY + 1);
  localparam logic [CW-1:0] FULL_COUNT = CW'(FRAME_PIXELS);
  localparam logic [RW-1:0] WAIT_LOAD  = RW'((RD_LATENCY > 1) ? RD_LATENCY - 2 : 0);

  typedef enum logic [2:0] {W_IDLE, W_SETUP, W_STROBE, W_HOLD, W_PRST} wstate_t;
  typedef enum logic [2:0] {R_IDLE, R_STROBE, R_WAIT, R_CAP, R_PRST} rstate_t;

  wstate_t       wstate;
  logic [WW-1:0] wcnt;
  logic [CW-1:0] pix_count;
  logic          prst_pending;
  logic          frame_full;
  logic          mem_write;
  logic          mem_reset_write_ptr;
  logic [3:0]    mem_write_data;
  logic          pix_ready;

  rstate_t       rstate;
  logic [RW-1:0] rcnt;
  logic          rd_busy;
  logic          rd_valid;
  logic [3:0]    rd_data;
  logic          mem_read;
  logic          mem_reset_read_ptr;

  // frame_start gates pix_ready directly so a coincident pixel is refused rather than lost.
  assign pix_ready = rst_n & (wstate == W_IDLE) & ~frame_full & ~prst_pending & ~bus.frame_start;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wstate              <= W_IDLE;
      wcnt                <= '0;
      pix_count           <= '0;
      prst_pending        <= 1'b0;
      frame_full          <= 1'b0;
      mem_write           <= 1'b0;
      mem_reset_write_ptr <= 1'b0;
      mem_write_data      <= '0;
    end else begin
      case (wstate)
        W_IDLE: begin
          if (prst_pending) begin
            wstate              <= W_PRST;
            mem_reset_write_ptr <= 1'b1;
          end else if (bus.pix_valid && pix_ready) begin
            wstate         <= W_SETUP;
            mem_write_data <= bus.pix_data;
            pix_count      <= pix_count + 1'b1;
            frame_full     <= ((pix_count + 1'b1) == FULL_COUNT);
          end
        end
        W_SETUP: begin
          wstate    <= W_STROBE;
          mem_write <= 1'b1;
          wcnt      <= WW'(WR_PULSE - 1);
        end
        W_STROBE: begin
          if (wcnt == '0) begin
            wstate    <= W_HOLD;
            mem_write <= 1'b0;
          end else begin
            wcnt <= wcnt - 1'b1;
          end
        end
        W_HOLD: wstate <= W_IDLE;
        W_PRST: begin
          wstate              <= W_IDLE;
          mem_reset_write_ptr <= 1'b0;
          pix_count           <= '0;
          frame_full          <= 1'b0;
          prst_pending        <= 1'b0;
        end
        default: wstate <= W_IDLE;
      endcase
      if (bus.frame_start) prst_pending <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rstate             <= R_IDLE;
      rcnt               <= '0;
      rd_busy            <= 1'b0;
      rd_valid           <= 1'b0;
      rd_data            <= '0;
      mem_read           <= 1'b0;
      mem_reset_read_ptr <= 1'b0;
    end else if (bus.rd_frame_start) begin
      rstate             <= R_PRST;
      rd_busy            <= 1'b1;
      rd_valid           <= 1'b0;
      mem_read           <= 1'b0;
      mem_reset_read_ptr <= 1'b1;
    end else begin
      case (rstate)
        R_IDLE: begin
          if (bus.rd_req) begin
            rstate   <= R_STROBE;
            rd_busy  <= 1'b1;
            mem_read <= 1'b1;
          end
        end
        R_STROBE: begin
          mem_read <= 1'b0;
          if (RD_LATENCY == 1) begin
            rstate   <= R_CAP;
            rd_data  <= bus.mem_read_data;
            rd_valid <= 1'b1;
          end else begin
            rstate <= R_WAIT;
            rcnt   <= WAIT_LOAD;
          end
        end
        R_WAIT: begin
          if (rcnt == '0) begin
            rstate   <= R_CAP;
            rd_data  <= bus.mem_read_data;
            rd_valid <= 1'b1;
          end else begin
            rcnt <= rcnt - 1'b1;
          end
        end
        R_CAP: begin
          rstate   <= R_IDLE;
          rd_valid <= 1'b0;
          rd_busy  <= 1'b0;
        end
        R_PRST: begin
          rstate             <= R_IDLE;
          mem_reset_read_ptr <= 1'b0;
          rd_busy            <= 1'b0;
        end
        default: rstate <= R_IDLE;
      endcase
    end
  end

  assign bus.pix_ready           = pix_ready;
  assign bus.frame_full          = frame_full;
  assign bus.mem_write           = mem_write;
  assign bus.mem_reset_write_ptr = mem_reset_write_ptr;
  assign bus.mem_write_data      = mem_write_data;
  assign bus.rd_busy             = rd_busy;
  assign bus.rd_valid            = rd_valid;
  assign bus.rd_data             = rd_data;
  assign bus.mem_read            = mem_read;
  assign bus.mem_reset_read_ptr  = mem_reset_read_ptr;
endmodule

// File: tb/tb_ext_frame_mem_ctrl.sv
// Directed bench for ext_frame_mem_ctrl: cycle tables for write and read sides plus
// hand sequences for reset, frame overflow and pointer-reset corner cases.
module tb_ext_frame_mem_ctrl;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_checks = 0;
  int   n_fail = 0;
  int   overlap_seen = 0;

  always #5 clk = ~clk;

  ext_frame_mem_ctrl_if bus();

  ext_frame_mem_ctrl #(.WR_PULSE(2), .RD_LATENCY(2), .FRAME_PIXELS(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {
    logic       fs;
    logic       pv;
    logic [3:0] pd;
    logic [7:0] exp;  // {pix_ready, mem_write, mem_reset_write_ptr, frame_full, mem_write_data}
  } wvec_t;

  typedef struct {
    logic       fs;
    logic       req;
    logic [3:0] md;
    logic [7:0] exp;  // {mem_read, mem_reset_read_ptr, rd_busy, rd_valid, rd_data}
  } rvec_t;

  wvec_t wv[10];
  rvec_t rv[13];

  function automatic logic [7:0] wpack();
    return {bus.pix_ready, bus.mem_write, bus.mem_reset_write_ptr, bus.frame_full, bus.mem_write_data};
  endfunction

  function automatic logic [7:0] rpack();
    return {bus.mem_read, bus.mem_reset_read_ptr, bus.rd_busy, bus.rd_valid, bus.rd_data};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic wstep(input logic fs, input logic pv, input logic [3:0] pd);
    @(posedge clk);
    #1;
    bus.frame_start = fs;
    bus.pix_valid   = pv;
    bus.pix_data    = pd;
    #1;
  endtask

  task automatic rstep(input logic fs, input logic req, input logic [3:0] md);
    @(posedge clk);
    #1;
    bus.rd_frame_start = fs;
    bus.rd_req         = req;
    bus.mem_read_data  = md;
    #1;
  endtask

  always @(negedge clk)
    if (rst_n && ((bus.mem_write && bus.mem_reset_write_ptr) || (bus.mem_read && bus.mem_reset_read_ptr)))
      overlap_seen++;

  initial begin
    int accepted;
    int bursts;
    int rp_pulses;
    logic prev_mw;
    logic acc5;

    wv[0] = '{1'b0, 1'b1, 4'hA, 8'h80};
    wv[1] = '{1'b0, 1'b0, 4'h0, 8'h0A};
    wv[2] = '{1'b0, 1'b0, 4'h0, 8'h4A};
    wv[3] = '{1'b0, 1'b0, 4'h0, 8'h4A};
    wv[4] = '{1'b0, 1'b0, 4'h0, 8'h0A};
    wv[5] = '{1'b0, 1'b0, 4'h0, 8'h8A};
    wv[6] = '{1'b1, 1'b1, 4'h5, 8'h0A};
    wv[7] = '{1'b0, 1'b0, 4'h0, 8'h0A};
    wv[8] = '{1'b0, 1'b0, 4'h0, 8'h2A};
    wv[9] = '{1'b0, 1'b0, 4'h0, 8'h8A};

    rv[0]  = '{1'b0, 1'b1, 4'h0, 8'h00};
    rv[1]  = '{1'b0, 1'b1, 4'h0, 8'hA0};
    rv[2]  = '{1'b0, 1'b0, 4'h7, 8'h20};
    rv[3]  = '{1'b0, 1'b0, 4'h0, 8'h37};
    rv[4]  = '{1'b0, 1'b0, 4'h0, 8'h07};
    rv[5]  = '{1'b0, 1'b0, 4'h0, 8'h07};
    rv[6]  = '{1'b0, 1'b1, 4'h5, 8'h07};
    rv[7]  = '{1'b1, 1'b0, 4'h5, 8'hA7};
    rv[8]  = '{1'b0, 1'b0, 4'h0, 8'h67};
    rv[9]  = '{1'b0, 1'b0, 4'h0, 8'h07};
    rv[10] = '{1'b1, 1'b1, 4'h0, 8'h07};
    rv[11] = '{1'b0, 1'b0, 4'h0, 8'h67};
    rv[12] = '{1'b0, 1'b0, 4'h0, 8'h07};

    bus.frame_start = 1'b0; bus.pix_valid = 1'b0; bus.pix_data = '0;
    bus.rd_frame_start = 1'b0; bus.rd_req = 1'b0; bus.mem_read_data = '0;

    repeat (3) @(posedge clk);
    #2;
    check("reset_outputs", {16'h0, wpack(), rpack()}, 32'h0);
    @(posedge clk);
    #1 rst_n = 1'b1;

    // Reset asserted while the strobe is active
    wstep(1'b0, 1'b1, 4'h3); check("t1_accept", wpack(), 8'h80);
    wstep(1'b0, 1'b0, 4'h0); check("t1_setup", wpack(), 8'h03);
    wstep(1'b0, 1'b0, 4'h0); check("t1_strobe", wpack(), 8'h43);
    rst_n = 1'b0;
    #1;
    check("t1_reset_now", {16'h0, wpack(), rpack()}, 32'h0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    #1;
    check("t1_after_release", wpack(), 8'h80);

    for (int i = 0; i < 10; i++) begin
      wstep(wv[i].fs, wv[i].pv, wv[i].pd);
      check($sformatf("wvec%0d", i), wpack(), wv[i].exp);
    end

    // frame_start arriving mid-strobe
    wstep(1'b0, 1'b1, 4'hB); check("t4_accept", wpack(), 8'h8A);
    wstep(1'b0, 1'b0, 4'h0); check("t4_setup", wpack(), 8'h0B);
    wstep(1'b1, 1'b0, 4'h0); check("t4_strobe1", wpack(), 8'h4B);
    wstep(1'b0, 1'b0, 4'h0); check("t4_strobe2", wpack(), 8'h4B);
    wstep(1'b0, 1'b0, 4'h0); check("t4_hold", wpack(), 8'h0B);
    wstep(1'b0, 1'b0, 4'h0); check("t4_idle_pend", wpack(), 8'h0B);
    wstep(1'b0, 1'b0, 4'h0); check("t4_prst", wpack(), 8'h2B);
    wstep(1'b0, 1'b0, 4'h0); check("t4_ready", wpack(), 8'h8B);

    // Stream six pixels into a four-pixel frame
    accepted = 0; bursts = 0; prev_mw = 1'b0;
    for (int c = 0; c < 40; c++) begin
      wstep(1'b0, 1'b1, 4'(accepted));
      if (bus.pix_ready) accepted++;
      if (bus.mem_write && !prev_mw) bursts++;
      prev_mw = bus.mem_write;
    end
    check("t3_accepted", accepted, 4);
    check("t3_bursts", bursts, 4);
    check("t3_full_state", wpack(), 8'h13);

    wstep(1'b1, 1'b1, 4'h4); check("t3_fs_refuse", wpack(), 8'h13);
    rp_pulses = 0; acc5 = 1'b0;
    for (int c = 0; c < 10; c++) begin
      wstep(1'b0, !acc5, 4'h4);
      if (bus.mem_reset_write_ptr) rp_pulses++;
      if (bus.pix_ready && !acc5) begin
        acc5 = 1'b1;
        check("t3_full_cleared", bus.frame_full, 1'b0);
      end
    end
    check("t3_rp_pulses", rp_pulses, 1);
    check("t3_pix5_accepted", acc5, 1'b1);
    check("t3_pix5_data", bus.mem_write_data, 4'h4);

    for (int i = 0; i < 13; i++) begin
      rstep(rv[i].fs, rv[i].req, rv[i].md);
      check($sformatf("rvec%0d", i), rpack(), rv[i].exp);
    end

    check("strobe_overlap", overlap_seen, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
